// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: bundles the requester, cache-line and backing-memory
// signals of cache_refill_ctrl so they travel as a single port.
// Ports: master = controller side, slave = requester/cache-line/memory side.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // requester side
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_rdata;
  // cache line
  logic [ADDR_W-1:0] line_addr;
  logic [DATA_W-1:0] line_val;
  logic              line_read;
  logic              line_write;
  logic              line_hit;
  logic [DATA_W-1:0] line_out_val;
  // backing memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;
  // read statistics
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output line_addr, line_val, line_read, line_write,
    input  line_hit, line_out_val,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output hit_count, miss_count
  );

  modport slave (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  line_addr, line_val, line_read, line_write,
    output line_hit, line_out_val,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: single-outstanding cache refill / write-through controller.
// Latency: read hit responds 3 cycles after accept; misses and writes add the
// memory handshake time. Backpressure: cpu_req_ready only in IDLE; mem request
// held stable until mem_req_ready.
// Ports: clock, reset_n (async, active-low), bus (cache_refill_ctrl_if.master).
module cache_refill_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  cache_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_line_read;
  logic              r_line_write;
  logic [DATA_W-1:0] r_line_val;
  logic              r_mem_req_valid;
  logic              r_mem_we;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The captured request feeds both the line and memory address/data, so
  // they stay stable for the whole transaction without extra registers.
  assign bus.cpu_req_ready  = r_ready;
  assign bus.cpu_resp_valid = r_resp_valid;
  assign bus.cpu_rdata      = r_rdata;
  assign bus.line_addr      = r_addr;
  assign bus.line_val       = r_line_val;
  assign bus.line_read      = r_line_read;
  assign bus.line_write     = r_line_write;
  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.hit_count      = r_hit_cnt;
  assign bus.miss_count     = r_miss_cnt;

  // Outputs are registered: each strobe is set on the edge that enters its
  // state and cleared on the edge that leaves it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_ready         <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_rdata         <= '0;
      r_line_read     <= 1'b0;
      r_line_write    <= 1'b0;
      r_line_val      <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
            r_ready <= 1'b0;
            if (bus.cpu_we) begin
              r_state         <= MEM_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_we        <= 1'b1;
            end else begin
              r_state     <= LOOKUP;
              r_line_read <= 1'b1;
            end
          end
        end

        LOOKUP: begin
          r_line_read <= 1'b0;
          r_state     <= CHECK;
        end

        // line_hit is registered by the cache line, so it is valid here,
        // one cycle after the line_read strobe.
        CHECK: begin
          if (bus.line_hit) begin
            r_rdata      <= bus.line_out_val;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
            if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else begin
            r_mem_req_valid <= 1'b1;
            r_mem_we        <= 1'b0;
            r_state         <= MEM_REQ;
            if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end

        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            if (r_we) begin
              // write-through: the line gets the CPU data once memory has it
              r_line_write <= 1'b1;
              r_line_val   <= r_wdata;
              r_state      <= FILL;
            end else begin
              r_state <= MEM_WAIT;
            end
          end
        end

        // Only this state listens to mem_resp_valid; stray returns elsewhere
        // (e.g. from a request dropped by reset) fall on deaf ears.
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_rdata      <= bus.mem_rdata;
            r_line_val   <= bus.mem_rdata;
            r_line_write <= 1'b1;
            r_state      <= FILL;
          end
        end

        FILL: begin
          r_line_write <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end

        RESP: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end

        default: begin
          r_state         <= IDLE;
          r_ready         <= 1'b1;
          r_resp_valid    <= 1'b0;
          r_line_read     <= 1'b0;
          r_line_write    <= 1'b0;
          r_mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed, table-driven bench for cache_refill_ctrl.
// A second instance with CNT_W=2 shadows the same inputs to watch saturation.
// Cache line and memory are modelled cycle by cycle inside the bench.
module tb_cache_refill_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  cache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) bm ();
  cache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  bs ();

  assign bs.cpu_req_valid  = bm.cpu_req_valid;
  assign bs.cpu_we         = bm.cpu_we;
  assign bs.cpu_addr       = bm.cpu_addr;
  assign bs.cpu_wdata      = bm.cpu_wdata;
  assign bs.line_hit       = bm.line_hit;
  assign bs.line_out_val   = bm.line_out_val;
  assign bs.mem_req_ready  = bm.mem_req_ready;
  assign bs.mem_resp_valid = bm.mem_resp_valid;
  assign bs.mem_rdata      = bm.mem_rdata;

  cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .bus(bm));
  cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) u_sat (
    .clock(clock), .reset_n(reset_n), .bus(bs));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          hit;
    logic [DW-1:0] lov;
    int            rdy_dly;
    int            resp_dly;
    logic [DW-1:0] mrd;
    logic [DW-1:0] e_rdata;
    int            e_hit;
    int            e_miss;
    int            e_lat;
    int            e_lw;
    logic [AW-1:0] e_lwa;
    logic [DW-1:0] e_lwv;
    int            e_mem;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int cyc, acc, lat, lw_n, lr_n, mem_n, resp_n, ovl, unst, cd;
    logic rdy_after, drop, prev_lr, m_we;
    logic [AW-1:0] lw_a, lr_a, m_a;
    logic [DW-1:0] lw_v, m_d;
    string p;
    acc = -1; lat = -1; lw_n = 0; lr_n = 0; mem_n = 0; resp_n = 0;
    ovl = 0; unst = 0; cd = -1; cyc = 0;
    rdy_after = 1'b0; drop = 1'b0; prev_lr = 1'b0; m_we = 1'b0;
    lw_a = '0; lr_a = '0; m_a = '0; lw_v = '0; m_d = '0;
    p = $sformatf("v%0d", idx);
    bm.cpu_we = v.we; bm.cpu_addr = v.addr; bm.cpu_wdata = v.wdata;
    bm.cpu_req_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (acc >= 0) begin
        if (bm.line_read) begin lr_n++; lr_a = bm.line_addr; end
        if (bm.line_write) begin lw_n++; lw_a = bm.line_addr; lw_v = bm.line_val; end
        if (bm.mem_req_valid) begin
          if (mem_n == 0) begin
            m_we = bm.mem_we; m_a = bm.mem_addr; m_d = bm.mem_wdata;
          end else if (m_we !== bm.mem_we || m_a !== bm.mem_addr || m_d !== bm.mem_wdata) begin
            unst++;
          end
          mem_n++;
        end
        if (32'(bm.line_read) + 32'(bm.line_write) + 32'(bm.mem_req_valid) > 1) ovl++;
        if (bm.cpu_resp_valid) begin
          resp_n++;
          if (lat < 0) lat = cyc - acc;
        end
        if (lat >= 0 && cyc - acc == lat + 1) rdy_after = bm.cpu_req_ready;
      end
      // cache line: hit/value appear the cycle after line_read
      bm.line_hit     = prev_lr & v.hit;
      bm.line_out_val = prev_lr ? v.lov : '0;
      prev_lr         = bm.line_read;
      // memory read return, resp_dly cycles after the accepting edge
      if (cd > 0) cd--;
      if (cd == 0) begin
        bm.mem_resp_valid = 1'b1; bm.mem_rdata = v.mrd; cd = -1;
      end else begin
        bm.mem_resp_valid = 1'b0;
      end
      bm.mem_req_ready = bm.mem_req_valid && (mem_n > v.rdy_dly);
      if (bm.mem_req_ready && !v.we) cd = v.resp_dly;
      if (acc < 0 && bm.cpu_req_ready) begin acc = cyc; drop = 1'b1; end
      if (lat >= 0 && cyc - acc >= lat + 1) break;
      step();
      cyc++;
      if (drop) begin bm.cpu_req_valid = 1'b0; drop = 1'b0; end
    end
    bm.mem_req_ready = 1'b0; bm.mem_resp_valid = 1'b0; bm.line_hit = 1'b0;
    if (lat < 0) begin
      errors++; checks++;
      $display("FAIL %s timeout: no cpu_resp_valid within budget", p);
    end else begin
      chk({p, " latency"}, 32'(lat), 32'(v.e_lat));
      chk({p, " ready after resp"}, 32'(rdy_after), 32'd1);
    end
    chk({p, " rdata"}, bm.cpu_rdata, v.e_rdata);
    chk({p, " hit_count"}, 32'(bm.hit_count), 32'(v.e_hit));
    chk({p, " miss_count"}, 32'(bm.miss_count), 32'(v.e_miss));
    chk({p, " sat hit_count"}, 32'(bs.hit_count), 32'(sat3(v.e_hit)));
    chk({p, " sat miss_count"}, 32'(bs.miss_count), 32'(sat3(v.e_miss)));
    chk({p, " resp pulses"}, 32'(resp_n), 32'd1);
    chk({p, " line_write count"}, 32'(lw_n), 32'(v.e_lw));
    if (v.e_lw > 0) begin
      chk({p, " line_write addr"}, 32'(lw_a), 32'(v.e_lwa));
      chk({p, " line_write val"}, lw_v, v.e_lwv);
    end
    chk({p, " line_read count"}, 32'(lr_n), v.we ? 32'd0 : 32'd1);
    if (!v.we) chk({p, " lookup addr"}, 32'(lr_a), 32'(v.addr));
    chk({p, " mem valid cycles"}, 32'(mem_n), (v.e_mem != 0) ? 32'(v.rdy_dly + 1) : 32'd0);
    if (v.e_mem != 0) begin
      chk({p, " mem_we"}, 32'(m_we), 32'(v.we));
      chk({p, " mem_addr"}, 32'(m_a), 32'(v.addr));
      if (v.we) chk({p, " mem_wdata"}, m_d, v.wdata);
    end
    chk({p, " mem fields unstable"}, 32'(unst), 32'd0);
    chk({p, " strobe overlap"}, 32'(ovl), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, resps, viol, bad, notrdy;
    logic outst, prev_lr, in_wait, go, drop;

    // we, addr, wdata, hit, lov, rdy_dly, resp_dly, mrd,
    // e_rdata, e_hit, e_miss, e_lat, e_lw, e_lwa, e_lwv, e_mem
    vt[0] = '{1'b0, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF, 0, 0, 32'h0,
              32'hDEADBEEF, 1, 0, 3,  0, 8'h00, 32'h0,        0};
    vt[1] = '{1'b0, 8'h22, 32'h0,        1'b0, 32'h55555555, 2, 3, 32'h12345678,
              32'h12345678, 1, 1, 10, 1, 8'h22, 32'h12345678, 1};
    vt[2] = '{1'b1, 8'h05, 32'hCAFEF00D, 1'b1, 32'h77777777, 1, 0, 32'h0,
              32'h12345678, 1, 1, 4,  1, 8'h05, 32'hCAFEF00D, 1};
    vt[3] = '{1'b0, 8'h7F, 32'h0,        1'b1, 32'hA5A5A5A5, 0, 0, 32'h0,
              32'hA5A5A5A5, 2, 1, 3,  0, 8'h00, 32'h0,        0};
    vt[4] = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h66666666, 0, 1, 32'h0BADF00D,
              32'h0BADF00D, 2, 2, 6,  1, 8'h00, 32'h0BADF00D, 1};
    vt[5] = '{1'b1, 8'hFF, 32'h11112222, 1'b0, 32'h0,        0, 0, 32'h0,
              32'h0BADF00D, 2, 2, 3,  1, 8'hFF, 32'h11112222, 1};
    vt[6] = '{1'b0, 8'h05, 32'h0,        1'b1, 32'hCAFEF00D, 0, 0, 32'h0,
              32'hCAFEF00D, 3, 2, 3,  0, 8'h00, 32'h0,        0};
    vt[7] = '{1'b0, 8'h33, 32'h0,        1'b1, 32'h00000001, 0, 0, 32'h0,
              32'h00000001, 4, 2, 3,  0, 8'h00, 32'h0,        0};
    vt[8] = '{1'b0, 8'h44, 32'h0,        1'b1, 32'hFFFFFFFF, 0, 0, 32'h0,
              32'hFFFFFFFF, 5, 2, 3,  0, 8'h00, 32'h0,        0};

    reset_n = 1'b0;
    bm.cpu_req_valid = 1'b0; bm.cpu_we = 1'b0; bm.cpu_addr = '0; bm.cpu_wdata = '0;
    bm.line_hit = 1'b0; bm.line_out_val = '0;
    bm.mem_req_ready = 1'b0; bm.mem_resp_valid = 1'b0; bm.mem_rdata = '0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset ready", 32'(bm.cpu_req_ready), 32'd1);
    chk("reset resp_valid", 32'(bm.cpu_resp_valid), 32'd0);
    chk("reset strobes", {29'd0, bm.line_read, bm.line_write, bm.mem_req_valid}, 32'd0);
    chk("reset rdata", bm.cpu_rdata, 32'd0);
    chk("reset hit_count", 32'(bm.hit_count), 32'd0);
    chk("reset miss_count", 32'(bm.miss_count), 32'd0);
    reset_n = 1'b1;
    step();
    chk("first cycle ready", 32'(bm.cpu_req_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_txn(vt[i], i);

    // reset while waiting on memory, then a stray return after release
    bm.cpu_we = 1'b0; bm.cpu_addr = 8'h66; bm.cpu_wdata = '0; bm.cpu_req_valid = 1'b1;
    in_wait = 1'b0;
    for (int g = 0; g < 30 && !in_wait; g++) begin
      bm.mem_req_ready = bm.mem_req_valid;
      go   = bm.mem_req_valid;
      drop = bm.cpu_req_ready;
      step();
      if (drop) bm.cpu_req_valid = 1'b0;
      if (go) in_wait = 1'b1;
    end
    bm.mem_req_ready = 1'b0;
    chk("rst reached mem_wait", 32'(in_wait), 32'd1);
    chk("rst pre miss_count", 32'(bm.miss_count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst ready", 32'(bm.cpu_req_ready), 32'd1);
    chk("rst strobes", {28'd0, bm.line_read, bm.line_write, bm.mem_req_valid, bm.cpu_resp_valid}, 32'd0);
    chk("rst rdata", bm.cpu_rdata, 32'd0);
    chk("rst hit_count", 32'(bm.hit_count), 32'd0);
    chk("rst miss_count", 32'(bm.miss_count), 32'd0);
    chk("rst sat hit_count", 32'(bs.hit_count), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bm.mem_resp_valid = 1'b1; bm.mem_rdata = 32'hBAD0BAD0;
    bad = 0; notrdy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 1) bm.mem_resp_valid = 1'b0;
      if (bm.cpu_resp_valid || bm.line_write || bm.line_read || bm.mem_req_valid) bad++;
      if (!bm.cpu_req_ready) notrdy++;
    end
    chk("stray resp activity", 32'(bad), 32'd0);
    chk("stray resp not idle", 32'(notrdy), 32'd0);
    chk("stray resp rdata", bm.cpu_rdata, 32'd0);
    chk("stray resp counters", {bm.hit_count, bm.miss_count}, 32'd0);

    // cpu_req_valid held high: hits serviced strictly one at a time
    bm.cpu_we = 1'b0; bm.cpu_addr = 8'h3C; bm.cpu_req_valid = 1'b1;
    accepts = 0; resps = 0; viol = 0; outst = 1'b0; prev_lr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bm.cpu_req_ready) begin
        if (outst) viol++;
        accepts++;
        outst = 1'b1;
      end
      if (bm.cpu_resp_valid) begin
        resps++;
        outst = 1'b0;
      end
      bm.line_hit     = prev_lr;
      bm.line_out_val = 32'h13579BDF;
      prev_lr         = bm.line_read;
      step();
    end
    bm.cpu_req_valid = 1'b0; bm.line_hit = 1'b0;
    chk("hold accepts", 32'(accepts), 32'd5);
    chk("hold resps", 32'(resps), 32'd5);
    chk("hold ready while busy", 32'(viol), 32'd0);
    chk("hold hit_count", 32'(bm.hit_count), 32'd5);
    chk("hold sat hit_count", 32'(bs.hit_count), 32'd3);
    chk("hold miss_count", 32'(bm.miss_count), 32'd0);
    chk("hold rdata", bm.cpu_rdata, 32'h13579BDF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 8, address width; DATA_W, 32, data width; CNT_W, 16, statistics counter width.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 cpu_req_valid  input  1  requester presents a request.
REQ-005 cpu_req_ready  output  1  controller accepts a request this cycle.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  ADDR_W  request address.
REQ-008 cpu_wdata  input  DATA_W  write data.
REQ-009 cpu_resp_valid  output  1  one-cycle response strobe.
REQ-010 cpu_rdata  output  DATA_W  read data, valid with cpu_resp_valid.
REQ-011 line_addr  output  ADDR_W  address driven to the cache line.
REQ-012 line_val  output  DATA_W  value driven to the cache line.
REQ-013 line_read / line_write  output  1 each  cache line read and write strobes.
REQ-014 line_hit  input  1  registered hit from the cache line, one cycle after line_read.
REQ-015 line_out_val  input  DATA_W  stored value from the cache line.
REQ-016 mem_req_valid  output  1  backing-memory request.
REQ-017 mem_req_ready  input  1  memory accepts the request.
REQ-018 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  memory request fields.
REQ-019 mem_resp_valid, mem_rdata  input  1/DATA_W  memory read return.
REQ-020 hit_count, miss_count  output  CNT_W each  read statistics.

Function
REQ-021 The FSM SHALL have the states IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL and RESP.
REQ-022 cpu_req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where valid and ready are both 1, and the controller SHALL capture addr, we and wdata on that edge.
REQ-023 On acceptance the FSM SHALL move to LOOKUP for a read and to MEM_REQ for a write.
REQ-024 In LOOKUP the controller SHALL drive line_read=1 and line_addr=captured addr for exactly one cycle, then go to CHECK.
REQ-025 In CHECK, if line_hit=1, the controller SHALL latch line_out_val into cpu_rdata, increment hit_count and go to RESP.
REQ-026 In CHECK, if line_hit=0, the controller SHALL increment miss_count and go to MEM_REQ with mem_we=0.
REQ-027 In MEM_REQ, mem_req_valid SHALL be 1 with all fields stable until mem_req_ready=1.
REQ-028 On the accepting edge in MEM_REQ, a read SHALL go to MEM_WAIT; a write SHALL go to FILL using line_val=cpu_wdata (write-through).
REQ-029 In MEM_WAIT the controller SHALL hold until mem_resp_valid=1, then latch mem_rdata into cpu_rdata and go to FILL; mem_resp_valid seen in any other state SHALL be ignored.
REQ-030 In FILL the controller SHALL drive line_write=1 for one cycle with line_addr=captured addr and line_val=fill data (mem_rdata for a read, cpu_wdata for a write), then go to RESP.
REQ-031 In RESP, cpu_resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; cpu_rdata SHALL hold its value until the next latch.
REQ-032 Read-hit latency: cpu_resp_valid SHALL be asserted in the third cycle after the accepting edge.
REQ-033 line_read, line_write and mem_req_valid SHALL never be asserted together, and each SHALL be 0 outside its own state.
REQ-034 Counters SHALL saturate at all-ones and SHALL NOT wrap; writes SHALL NOT change either counter.
REQ-035 Requests are not pipelined; at most one SHALL be outstanding.

Reset
REQ-036 Asserting reset_n=0 at any time, including mid-transaction, SHALL immediately force IDLE and clear all strobes, hit_count, miss_count and cpu_rdata to 0; the in-flight request is dropped with no response.
REQ-037 After deassertion, cpu_req_ready SHALL be 1 in the first cycle, and late memory responses from a dropped request SHALL be ignored.

Verification
REQ-038 Read 0x10 with line_hit=1 and line_out_val=0xDEADBEEF -> resp in the 3rd cycle after accept, rdata=0xDEADBEEF, hit_count=1, no mem_req_valid.
REQ-039 Read 0x22 with line_hit=0, mem_req_ready delayed 2 cycles, mem_rdata=0x12345678 after 3 cycles -> one line_write with addr 0x22 and val 0x12345678, then resp rdata=0x12345678, miss_count=1.
REQ-040 Write 0x05=0xCAFEF00D -> mem_req_valid with mem_we=1, then line_write with addr 0x05 and val 0xCAFEF00D, then resp; counters unchanged.
REQ-041 Assert reset_n=0 during MEM_WAIT, then a spurious mem_resp_valid after release -> no cpu_resp_valid, state IDLE, counters 0.
REQ-042 With CNT_W=2, issue 5 read hits -> hit_count stays at 3.
REQ-043 Hold cpu_req_valid high continuously -> ready is 1 only in IDLE, and requests are serviced strictly one at a time.
